// File: rtl/pipe_scheduler.sv
// Game-level scheduler for the scrolling pipe field: IDLE/PLAY/OVER FSM, scroll strobes, pipe spawning and score.
// Optional macro DIFFICULTY_RAMP_EN: shrink spawn spacing every LEVEL_PIPES spawns, down to MIN_SPACING.
module pipe_scheduler #(
  parameter int GAP_H        = 3,
  parameter int INIT_SPACING = 12,
  parameter int MIN_SPACING  = 6,
  parameter int LEVEL_PIPES  = 4,
  parameter int BIRD_COL     = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        tick,
  input  logic        start,
  input  logic        collision,
  output logic        scroll_en,
  output logic [15:0] pipe_col,
  output logic        spawn,
  output logic        pipes_clear,
  output logic        playing,
  output logic        game_over,
  output logic [7:0]  score
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [3:0]  INIT_SP   = 4'(INIT_SPACING);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        scroll_en_q, scroll_en_d;
  logic        spawn_q, spawn_d;
  logic [15:0] pipe_col_q, pipe_col_d;
  logic [3:0]  spacing_cnt_q, spacing_cnt_d;
  logic [15:0] marker_q, marker_d;
  logic [7:0]  score_q, score_d;
  logic [3:0]  spacing_cur;

`ifdef DIFFICULTY_RAMP_EN
  localparam logic [3:0] MIN_SP   = 4'(MIN_SPACING);
  localparam logic [3:0] LEVEL_N  = 4'(LEVEL_PIPES);
  logic [3:0] spacing_q, spacing_d;
  logic [3:0] level_cnt_q, level_cnt_d;
  logic [3:0] level_next;
  assign spacing_cur = spacing_q;
`else
  assign spacing_cur = INIT_SP;
`endif

  // Gap start is folded back into range so the opening never wraps past row 15.
  function automatic logic [15:0] gap_pattern(input logic [3:0] seed);
    logic [15:0] pat;
    int          g;
    g = int'(seed);
    if (g > 16 - GAP_H) g = g - (16 - GAP_H);
    for (int i = 0; i < 16; i++) begin
      pat[i] = !((i >= g) && (i < g + GAP_H));
    end
    return pat;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    scroll_en_d   = 1'b0;
    spawn_d       = 1'b0;
    pipe_col_d    = 16'h0000;
    spacing_cnt_d = spacing_cnt_q;
    marker_d      = marker_q;
    score_d       = score_q;
`ifdef DIFFICULTY_RAMP_EN
    spacing_d     = spacing_q;
    level_cnt_d   = level_cnt_q;
    level_next    = level_cnt_q + 4'd1;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_PLAY;
          score_d       = 8'd0;
          spacing_cnt_d = 4'd0;
          marker_d      = 16'h0000;
`ifdef DIFFICULTY_RAMP_EN
          spacing_d     = INIT_SP;
          level_cnt_d   = 4'd0;
`endif
        end
      end
      S_PLAY: begin
        if (collision) begin
          state_d = S_OVER;
        end else if (tick) begin
          scroll_en_d = 1'b1;
          if (spacing_cnt_q == 4'd0) begin
            spawn_d       = 1'b1;
            pipe_col_d    = gap_pattern(lfsr_q[3:0]);
            spacing_cnt_d = spacing_cur - 4'd1;
`ifdef DIFFICULTY_RAMP_EN
            // Spacing change only takes effect at the following reload.
            if (level_next == LEVEL_N) begin
              level_cnt_d = 4'd0;
              if (spacing_q > MIN_SP) spacing_d = spacing_q - 4'd1;
            end else begin
              level_cnt_d = level_next;
            end
`endif
          end else begin
            spacing_cnt_d = spacing_cnt_q - 4'd1;
          end
          // Marker mirrors the field, so the score moves on the same edge as the strobe.
          marker_d = {marker_q[14:0], spawn_d};
          if (marker_d[BIRD_COL]) score_d = sat_inc(score_q);
        end
      end
      S_OVER: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      scroll_en_q   <= 1'b0;
      spawn_q       <= 1'b0;
      pipe_col_q    <= 16'h0000;
      spacing_cnt_q <= 4'd0;
      marker_q      <= 16'h0000;
      score_q       <= 8'd0;
`ifdef DIFFICULTY_RAMP_EN
      spacing_q     <= INIT_SP;
      level_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      scroll_en_q   <= scroll_en_d;
      spawn_q       <= spawn_d;
      pipe_col_q    <= pipe_col_d;
      spacing_cnt_q <= spacing_cnt_d;
      marker_q      <= marker_d;
      score_q       <= score_d;
`ifdef DIFFICULTY_RAMP_EN
      spacing_q     <= spacing_d;
      level_cnt_q   <= level_cnt_d;
`endif
    end
  end

  assign scroll_en   = scroll_en_q;
  assign spawn       = spawn_q;
  assign pipe_col    = pipe_col_q;
  assign score       = score_q;
  assign pipes_clear = (state_q == S_IDLE);
  assign playing     = (state_q == S_PLAY);
  assign game_over   = (state_q == S_OVER);

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: vector table for the FSM, plus long play runs against a reference model.
module tb_pipe_scheduler;

  localparam int GAP_H        = 3;
  localparam int INIT_SPACING = 12;
  localparam int MIN_SPACING  = 6;
  localparam int LEVEL_PIPES  = 4;
  localparam int BIRD_COL     = 2;

  logic        Clock = 1'b0;
  logic        Reset, tick, start, collision;
  logic        scroll_en, spawn, pipes_clear, playing, game_over;
  logic [15:0] pipe_col;
  logic [7:0]  score;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  pipe_scheduler #(
    .GAP_H(GAP_H), .INIT_SPACING(INIT_SPACING), .MIN_SPACING(MIN_SPACING),
    .LEVEL_PIPES(LEVEL_PIPES), .BIRD_COL(BIRD_COL)
  ) dut (
    .Clock(Clock), .Reset(Reset), .tick(tick), .start(start), .collision(collision),
    .scroll_en(scroll_en), .pipe_col(pipe_col), .spawn(spawn), .pipes_clear(pipes_clear),
    .playing(playing), .game_over(game_over), .score(score)
  );

  // Reference LFSR: free-running from the reset seed.
  logic [15:0] m_lfsr;
  logic [15:0] lfsr_before;
  always @(posedge Clock) begin
    if (Reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  function automatic logic [15:0] exp_pattern(input logic [15:0] l);
    int          g;
    logic [15:0] hole;
    g = int'(l[3:0]);
    if (g > 16 - GAP_H) g = g - (16 - GAP_H);
    hole = 16'((1 << GAP_H) - 1) << g;
    return ~hole;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic t, input logic c);
    @(negedge Clock);
    Reset = r; start = s; tick = t; collision = c;
    lfsr_before = m_lfsr;
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic       r, s, t, c;
    logic       e_scroll, e_spawn, e_play, e_over, e_clear;
    logic [7:0] e_score;
  } vec_t;

  vec_t tbl[15];

  task automatic setv(input int i, input logic r, input logic s, input logic t, input logic c,
                      input logic sc, input logic sp, input logic pl, input logic ov,
                      input logic cl, input logic [7:0] scr);
    tbl[i] = '{r, s, t, c, sc, sp, pl, ov, cl, scr};
  endtask

  // Behavioural reference for a run of consecutive ticks starting right after IDLE->PLAY.
  task automatic play_run(input int n_ticks, input string tag);
    int          m_cnt, m_spacing, m_level, m_score, spawns, second_at;
    logic [15:0] m_marker;
    logic        e_spawn;
    m_cnt = 0; m_spacing = INIT_SPACING; m_level = 0; m_score = 0; m_marker = 16'h0;
    spawns = 0; second_at = 0;
    for (int k = 1; k <= n_ticks; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      e_spawn = (m_cnt == 0);
      if (e_spawn) begin
        m_cnt = m_spacing - 1;
        spawns++;
        if (spawns == 2) second_at = k;
`ifdef DIFFICULTY_RAMP_EN
        m_level++;
        if (m_level == LEVEL_PIPES) begin
          m_level = 0;
          if (m_spacing > MIN_SPACING) m_spacing--;
        end
`endif
      end else begin
        m_cnt--;
      end
      m_marker = {m_marker[14:0], e_spawn};
      if (m_marker[BIRD_COL] && m_score < 255) m_score++;
      chk({tag, "_scroll"}, 32'(scroll_en), 32'd1);
      chk({tag, "_spawn"}, 32'(spawn), 32'(e_spawn));
      chk({tag, "_pipe_col"}, 32'(pipe_col), e_spawn ? 32'(exp_pattern(lfsr_before)) : 32'd0);
      chk({tag, "_score"}, 32'(score), 32'(m_score));
    end
    chk({tag, "_second_spawn_scroll"}, 32'(second_at), 32'd13);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; tick = 1'b0; collision = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_scroll", 32'(scroll_en), 32'd0);
    chk("rst_clear", 32'(pipes_clear), 32'd1);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_pipe_col", 32'(pipe_col), 32'd0);

    // IDLE must ignore ticks and collisions entirely.
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'(i % 2));
      chk("idle_scroll", 32'(scroll_en), 32'd0);
      chk("idle_clear", 32'(pipes_clear), 32'd1);
      chk("idle_score", 32'(score), 32'd0);
      chk("idle_pipe_col", 32'(pipe_col), 32'd0);
    end

    //      i   R  S  T  C   scr spn ply ovr clr score
    setv(0,  1, 0, 1, 0,   0,  0,  0,  0,  1,  8'd0);
    setv(1,  0, 0, 1, 1,   0,  0,  0,  0,  1,  8'd0);
    setv(2,  0, 1, 0, 0,   0,  0,  1,  0,  0,  8'd0);
    setv(3,  0, 0, 1, 0,   1,  1,  1,  0,  0,  8'd0);
    setv(4,  0, 0, 0, 0,   0,  0,  1,  0,  0,  8'd0);
    setv(5,  0, 1, 0, 0,   0,  0,  1,  0,  0,  8'd0);
    setv(6,  0, 0, 1, 0,   1,  0,  1,  0,  0,  8'd0);
    setv(7,  0, 0, 1, 0,   1,  0,  1,  0,  0,  8'd1);
    setv(8,  0, 0, 1, 0,   1,  0,  1,  0,  0,  8'd1);
    setv(9,  0, 0, 1, 1,   0,  0,  0,  1,  0,  8'd1);
    setv(10, 0, 0, 1, 0,   0,  0,  0,  1,  0,  8'd1);
    setv(11, 0, 1, 0, 0,   0,  0,  0,  0,  1,  8'd1);
    setv(12, 0, 1, 0, 0,   0,  0,  1,  0,  0,  8'd0);
    setv(13, 0, 0, 1, 0,   1,  1,  1,  0,  0,  8'd0);
    setv(14, 1, 0, 1, 0,   0,  0,  0,  0,  1,  8'd0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].t, tbl[i].c);
      chk($sformatf("v%0d_scroll", i), 32'(scroll_en), 32'(tbl[i].e_scroll));
      chk($sformatf("v%0d_spawn", i), 32'(spawn), 32'(tbl[i].e_spawn));
      chk($sformatf("v%0d_pipe_col", i), 32'(pipe_col),
          tbl[i].e_spawn ? 32'(exp_pattern(lfsr_before)) : 32'd0);
      chk($sformatf("v%0d_playing", i), 32'(playing), 32'(tbl[i].e_play));
      chk($sformatf("v%0d_over", i), 32'(game_over), 32'(tbl[i].e_over));
      chk($sformatf("v%0d_clear", i), 32'(pipes_clear), 32'(tbl[i].e_clear));
      chk($sformatf("v%0d_score", i), 32'(score), 32'(tbl[i].e_score));
    end

    // Short run after an odd number of idle cycles to shift the LFSR phase.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    play_run(60, "run1");

    // Long run through score saturation, then collide and recheck the frozen score.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    play_run(3100, "run2");
    chk("sat_score", 32'(score), 32'd255);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("end_over", 32'(game_over), 32'd1);
    chk("end_scroll", 32'(scroll_en), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("end_frozen", 32'(score), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
